capture_controller: RTL and testbench
=====================================

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single rising-edge clock for all state.
REQ-002 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port validIn, input, 1 bit: qualifies dataIn as a sample.
REQ-004 The block SHALL have the port dataIn, input, 32 bits: channel sample.
REQ-005 The block SHALL have the port run, input, 1 bit: trigger fired, driven by the trigger block.
REQ-006 The block SHALL have the port arm, input, 1 bit: single-cycle pulse that starts or restarts a capture.
REQ-007 The block SHALL have the port wrSize, input, 1 bit: load the size register from config_data.
REQ-008 The block SHALL have the port config_data, input, 32 bits: [31:16] readCount R, [15:0] delayCount D.
REQ-009 The block SHALL have the port busy, input, 1 bit: downstream transmitter cannot accept a word.
REQ-010 The block SHALL have the port memRdData, input, 32 bits: sample memory read data, valid 1 cycle after memoryRead.
REQ-011 The block SHALL have the port memoryWrite, output, 1 bit: single-cycle write strobe.
REQ-012 The block SHALL have the port memoryLastWrite, output, 1 bit: marks the final post-trigger write.
REQ-013 The block SHALL have the port memWrData, output, 32 bits: write data.
REQ-014 The block SHALL have the port memoryRead, output, 1 bit: single-cycle read strobe.
REQ-015 The block SHALL have the port send, output, 1 bit: single-cycle strobe; dataOut is valid.
REQ-016 The block SHALL have the port dataOut, output, 32 bits: word to the transmitter.

Function
REQ-017 States SHALL be IDLE, SAMPLE, DELAY, READ and READWAIT, with a 16-bit counter cnt.
REQ-018 wrSize SHALL load R and D only in IDLE and SHALL be ignored in all other states.
REQ-019 IDLE: arm -> SAMPLE with cnt=0; no memory or send strobes.
REQ-020 SAMPLE and DELAY: each validIn cycle SHALL produce memoryWrite=1 on the next cycle, with memWrData = that cycle's dataIn (1-cycle latency).
REQ-021 SAMPLE: a validIn cycle with run=1 SHALL be the trigger sample and is written like any other sample; then D=0 -> READ with memoryLastWrite asserted on that write, else -> DELAY with cnt=0.
REQ-022 SAMPLE: run=1 with validIn=0 SHALL be ignored.
REQ-023 DELAY: each validIn cycle SHALL increment cnt; the validIn cycle on which cnt+1==D SHALL be written with memoryLastWrite=1, and the state -> READ with cnt=0, giving exactly D post-trigger samples after the trigger sample.
REQ-024 memoryLastWrite SHALL only be asserted coincident with memoryWrite.
REQ-025 READ: memoryRead=1 for one cycle -> READWAIT.
REQ-026 READWAIT: memRdData SHALL be captured on the cycle after memoryRead into a holding register.
REQ-027 READWAIT: send=1 and dataOut=held word SHALL occur on the first cycle with busy=0 at or after capture, and send SHALL NOT assert while busy=1.
REQ-028 After each send, if cnt==R -> IDLE, else cnt+1 and -> READ, giving exactly R+1 words per capture.
REQ-029 dataOut SHALL hold the last sent word until the next send.
REQ-030 arm in any non-IDLE state SHALL abort: -> SAMPLE with cnt=0, no strobes on that cycle, and any pending word discarded.
REQ-031 arm and run in the same cycle SHALL be resolved with arm winning.
REQ-032 R=65535 and D=65535 SHALL work without counter overflow, since comparisons are by equality and cnt never exceeds 65535.
REQ-033 memoryWrite, memoryRead and send SHALL be mutually exclusive in any cycle.

Reset
REQ-034 reset_n=0 SHALL immediately force state IDLE, cnt=0, R=0, D=0, and all outputs to 0, including memWrData and dataOut.
REQ-035 Reset deassertion SHALL take effect on the next clock edge, and reset mid-capture or mid-readback SHALL discard all progress.

Verification
REQ-036 The bench SHALL load D=3, R=2, arm, run high on the 5th valid sample, then drive continuous validIn -> 8 writes total, memoryLastWrite on write 8 only, then 3 sends.
REQ-037 The bench SHALL load D=0, R=0, arm, run with the 1st valid sample -> exactly 1 write with memoryLastWrite, 1 memoryRead, 1 send.
REQ-038 The bench SHALL hold busy=1 for 10 cycles in READWAIT -> no send, dataOut unchanged; busy falls -> send next cycle with the correct word.
REQ-039 The bench SHALL drive run=1 with validIn=0 in SAMPLE -> stays SAMPLE, no write; the later run with validIn -> trigger.
REQ-040 The bench SHALL pulse arm during the second readback word -> send stops, SAMPLE re-entered, cnt=0, writes resume on the next validIn.
REQ-041 The bench SHALL assert reset_n=0 asynchronously mid-DELAY -> outputs 0 within the same cycle, IDLE; arm ignored while reset_n=0.

Source files
------------

// File: rtl/capture_controller.sv
// capture_controller
//
// Purpose:
//   Sequences a logic-analyser style capture. After an arm pulse the block
//   writes every qualified sample into sample memory. The first qualified
//   sample seen with run high is the trigger sample. After it, exactly D
//   more samples are written, and the final write is tagged with
//   memoryLastWrite. The block then reads R+1 words back out of memory and
//   hands them to the transmitter one at a time, waiting while the
//   transmitter reports busy.
//
// Ports:
//   clock            rising-edge clock for all state
//   reset_n          asynchronous active-low reset
//   validIn          qualifies dataIn as a sample
//   dataIn[31:0]     channel sample
//   run              trigger fired, from the trigger block
//   arm              single-cycle pulse that starts or restarts a capture
//   wrSize           load readCount/delayCount from config_data (IDLE only)
//   config_data[31:0]  [31:16] readCount R, [15:0] delayCount D
//   busy             transmitter cannot accept a word
//   memRdData[31:0]  memory read data, valid the cycle after memoryRead
//   memoryWrite      single-cycle write strobe
//   memoryLastWrite  marks the final post-trigger write
//   memWrData[31:0]  write data
//   memoryRead       single-cycle read strobe
//   send             single-cycle strobe, dataOut is valid
//   dataOut[31:0]    word to the transmitter, held until the next send
module capture_controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        validIn,
  input  logic [31:0] dataIn,
  input  logic        run,
  input  logic        arm,
  input  logic        wrSize,
  input  logic [31:0] config_data,
  input  logic        busy,
  input  logic [31:0] memRdData,
  output logic        memoryWrite,
  output logic        memoryLastWrite,
  output logic [31:0] memWrData,
  output logic        memoryRead,
  output logic        send,
  output logic [31:0] dataOut
);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    DELAY,
    READ,
    READWAIT
  } State;

  State        state, stateNext;
  logic [15:0] cnt, cntNext;
  logic [15:0] readCount, readCountNext;
  logic [15:0] delayCount, delayCountNext;
  logic [31:0] heldWord, heldWordNext;
  logic        heldValid, heldValidNext;
  logic        capturePending, capturePendingNext;

  logic        memoryWriteNext;
  logic        memoryLastWriteNext;
  logic [31:0] memWrDataNext;
  logic        memoryReadNext;
  logic        sendNext;
  logic [31:0] dataOutNext;

  // State and output register. Every output is registered, so the strobes
  // appear one cycle after the FSM decides on them. The write path therefore
  // has its one-cycle latency and the outputs are glitch free. Reset clears
  // everything, including the data buses and the size register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      readCount       <= '0;
      delayCount      <= '0;
      heldWord        <= '0;
      heldValid       <= 1'b0;
      capturePending  <= 1'b0;
      memoryWrite     <= 1'b0;
      memoryLastWrite <= 1'b0;
      memWrData       <= '0;
      memoryRead      <= 1'b0;
      send            <= 1'b0;
      dataOut         <= '0;
    end else begin
      state           <= stateNext;
      cnt             <= cntNext;
      readCount       <= readCountNext;
      delayCount      <= delayCountNext;
      heldWord        <= heldWordNext;
      heldValid       <= heldValidNext;
      capturePending  <= capturePendingNext;
      memoryWrite     <= memoryWriteNext;
      memoryLastWrite <= memoryLastWriteNext;
      memWrData       <= memWrDataNext;
      memoryRead      <= memoryReadNext;
      send            <= sendNext;
      dataOut         <= dataOutNext;
    end
  end

  // Next-state and next-output logic. Strobes default low and data registers
  // default to holding. Arm is checked before the per-state behaviour, so it
  // beats a simultaneous run and aborts any capture or readback in progress.
  // The write strobe only follows from SAMPLE/DELAY, and the read strobe
  // only from READ. Send is only decided in READWAIT on a cycle that issues
  // neither of the others. These three strobes therefore never coincide.
  always_comb begin
    stateNext           = state;
    cntNext             = cnt;
    readCountNext       = readCount;
    delayCountNext      = delayCount;
    heldWordNext        = heldWord;
    heldValidNext       = heldValid;
    capturePendingNext  = 1'b0;
    memoryWriteNext     = 1'b0;
    memoryLastWriteNext = 1'b0;
    memWrDataNext       = memWrData;
    memoryReadNext      = 1'b0;
    sendNext            = 1'b0;
    dataOutNext         = dataOut;

    if (state == IDLE && wrSize) begin
      readCountNext  = config_data[31:16];
      delayCountNext = config_data[15:0];
    end

    if (arm) begin
      stateNext     = SAMPLE;
      cntNext       = '0;
      heldValidNext = 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end

        SAMPLE: begin
          if (validIn) begin
            memoryWriteNext = 1'b1;
            memWrDataNext   = dataIn;
            if (run) begin
              cntNext = '0;
              if (delayCount == 16'd0) begin
                memoryLastWriteNext = 1'b1;
                stateNext           = READ;
              end else begin
                stateNext = DELAY;
              end
            end
          end
        end

        // cnt counts post-trigger samples already written. It stops at D-1,
        // so it never wraps even when D is 65535.
        DELAY: begin
          if (validIn) begin
            memoryWriteNext = 1'b1;
            memWrDataNext   = dataIn;
            if (cnt + 16'd1 == delayCount) begin
              memoryLastWriteNext = 1'b1;
              cntNext             = '0;
              stateNext           = READ;
            end else begin
              cntNext = cnt + 16'd1;
            end
          end
        end

        READ: begin
          memoryReadNext = 1'b1;
          stateNext      = READWAIT;
        end

        // The read strobe is visible during the first READWAIT cycle. The
        // memory answers on the cycle after that, which capturePending marks.
        // cnt counts words already sent and stops at R, so R+1 words go out.
        READWAIT: begin
          capturePendingNext = memoryRead;
          if (capturePending) begin
            heldWordNext  = memRdData;
            heldValidNext = 1'b1;
          end else if (heldValid && !busy) begin
            sendNext      = 1'b1;
            dataOutNext   = heldWord;
            heldValidNext = 1'b0;
            if (cnt == readCount) begin
              stateNext = IDLE;
            end else begin
              cntNext   = cnt + 16'd1;
              stateNext = READ;
            end
          end
        end

        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
// tb_capture_controller
//
// Purpose:
//   Directed self-checking bench for capture_controller. A small memory
//   model answers reads with a word derived from the read's sequence number.
//   A negedge monitor logs every write and send so that each scenario task
//   can compare counts and data against hand-computed values.
module tb_capture_controller;

  logic        clock;
  logic        reset_n;
  logic        validIn;
  logic [31:0] dataIn;
  logic        run;
  logic        arm;
  logic        wrSize;
  logic [31:0] config_data;
  logic        busy;
  logic [31:0] memRdData;
  logic        memoryWrite;
  logic        memoryLastWrite;
  logic [31:0] memWrData;
  logic        memoryRead;
  logic        send;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

  int wrTotal = 0;
  int lastTotal = 0;
  int lastIdx = -1;
  int sendTotal = 0;
  int totalReads = 0;
  int exclViol = 0;
  int orphanLast = 0;
  logic [31:0] wrLog [1024];
  logic [31:0] sendLog [1024];

  capture_controller dut (
    .clock(clock),
    .reset_n(reset_n),
    .validIn(validIn),
    .dataIn(dataIn),
    .run(run),
    .arm(arm),
    .wrSize(wrSize),
    .config_data(config_data),
    .busy(busy),
    .memRdData(memRdData),
    .memoryWrite(memoryWrite),
    .memoryLastWrite(memoryLastWrite),
    .memWrData(memWrData),
    .memoryRead(memoryRead),
    .send(send),
    .dataOut(dataOut)
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample memory model. Read number k returns A000_0000 + k on the cycle
  // after its read strobe.
  always @(posedge clock) begin
    if (memoryRead) begin
      memRdData  <= 32'hA000_0000 + totalReads;
      totalReads <= totalReads + 1;
    end
  end

  // Output monitor. It samples on the falling edge, where the registered
  // outputs are stable. It logs the writes and sends, and counts strobe
  // overlaps and any memoryLastWrite that arrives without memoryWrite.
  always @(negedge clock) begin
    if (memoryWrite) begin
      wrLog[wrTotal % 1024] = memWrData;
      if (memoryLastWrite) begin
        lastTotal = lastTotal + 1;
        lastIdx   = wrTotal;
      end
      wrTotal = wrTotal + 1;
    end
    if (memoryLastWrite && !memoryWrite) orphanLast = orphanLast + 1;
    if (send) begin
      sendLog[sendTotal % 1024] = dataOut;
      sendTotal = sendTotal + 1;
    end
    if (int'(memoryWrite) + int'(memoryRead) + int'(send) > 1) exclViol = exclViol + 1;
  end

  // Watchdog so that a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n cycles. Control returns 1 ns after the rising edge, which is
  // where inputs are driven and registered outputs are sampled.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one cycle of sample-side inputs.
  task automatic applyStimulus(input logic v, input logic r, input logic [31:0] d);
    validIn = v;
    run     = r;
    dataIn  = d;
    cyc(1);
  endtask

  task automatic loadConfig(input logic [15:0] r, input logic [15:0] d);
    wrSize      = 1'b1;
    config_data = {r, d};
    cyc(1);
    wrSize      = 1'b0;
    config_data = '0;
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  // Bounded waits. If a bound runs out, the count checks that follow fail.
  task automatic waitSends(input int target, input int budget);
    int n = 0;
    while (sendTotal < target && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic waitReads(input int target, input int budget);
    int n = 0;
    while (totalReads < target && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  // Reset holds every output at zero. IDLE ignores samples and run until it
  // is armed.
  task automatic test_reset();
    int wB;
    cyc(2);
    checks++;
    if ({memoryWrite, memoryLastWrite, memoryRead, send} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {memoryWrite, memoryLastWrite, memoryRead, send});
    end
    checks++;
    if (memWrData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_memWrData: got %h expected 00000000", memWrData);
    end
    checks++;
    if (dataOut !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_dataOut: got %h expected 00000000", dataOut);
    end
    reset_n = 1'b1;
    wB = wrTotal;
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEF0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    cyc(3);
    checks++;
    if (wrTotal - wB !== 0 || sendTotal !== 0) begin
      errors++;
      $display("[TB] FAIL idle_no_activity: got writes %0d sends %0d expected 0 0", wrTotal - wB, sendTotal);
    end
  endtask

  // D=3, R=2, trigger on the 5th sample: 8 writes, the last one tagged, then
  // 3 sends. A wrSize pulse in SAMPLE with D=0 data must be ignored.
  task automatic test_basic();
    int wB, sB, rB;
    wB = wrTotal; sB = sendTotal; rB = totalReads;
    loadConfig(16'd2, 16'd3);
    pulseArm();
    wrSize      = 1'b1;
    config_data = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'h1000_0000);
    wrSize      = 1'b0;
    for (int k = 1; k < 12; k++) applyStimulus(1'b1, (k == 4), 32'h1000_0000 + k);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitSends(sB + 3, 300);
    cyc(5);
    checks++;
    if (wrTotal - wB !== 8) begin
      errors++;
      $display("[TB] FAIL basic_writes: got %0d expected 8", wrTotal - wB);
    end
    checks++;
    if (lastIdx !== wB + 7 || lastTotal !== 1) begin
      errors++;
      $display("[TB] FAIL basic_last: got index %0d count %0d expected %0d 1", lastIdx, lastTotal, wB + 7);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wrLog[(wB + k) % 1024] !== 32'h1000_0000 + k) begin
        errors++;
        $display("[TB] FAIL basic_wrdata%0d: got %h expected %h", k, wrLog[(wB + k) % 1024], 32'h1000_0000 + k);
      end
    end
    checks++;
    if (totalReads - rB !== 3 || sendTotal - sB !== 3) begin
      errors++;
      $display("[TB] FAIL basic_readback: got reads %0d sends %0d expected 3 3", totalReads - rB, sendTotal - sB);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sendLog[(sB + k) % 1024] !== 32'hA000_0000 + rB + k) begin
        errors++;
        $display("[TB] FAIL basic_send%0d: got %h expected %h", k, sendLog[(sB + k) % 1024], 32'hA000_0000 + rB + k);
      end
    end
  endtask

  // D=0, R=0, trigger on the first sample: a single tagged write, a single
  // read and a single send. dataOut then keeps the sent word.
  task automatic test_zero(output logic [31:0] sentWord);
    int wB, sB, rB, lB;
    wB = wrTotal; sB = sendTotal; rB = totalReads; lB = lastTotal;
    sentWord = 32'hA000_0000 + rB;
    loadConfig(16'd0, 16'd0);
    pulseArm();
    applyStimulus(1'b1, 1'b1, 32'h2000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitSends(sB + 1, 100);
    cyc(5);
    checks++;
    if (wrTotal - wB !== 1 || lastTotal - lB !== 1 || lastIdx !== wB) begin
      errors++;
      $display("[TB] FAIL zero_writes: got writes %0d last %0d expected 1 1", wrTotal - wB, lastTotal - lB);
    end
    checks++;
    if (wrLog[wB % 1024] !== 32'h2000_0000) begin
      errors++;
      $display("[TB] FAIL zero_wrdata: got %h expected 20000000", wrLog[wB % 1024]);
    end
    checks++;
    if (totalReads - rB !== 1 || sendTotal - sB !== 1) begin
      errors++;
      $display("[TB] FAIL zero_readback: got reads %0d sends %0d expected 1 1", totalReads - rB, sendTotal - sB);
    end
    checks++;
    if (dataOut !== sentWord) begin
      errors++;
      $display("[TB] FAIL zero_dataOut_hold: got %h expected %h", dataOut, sentWord);
    end
  endtask

  // Busy held for 10 cycles with a word waiting: no send and dataOut keeps
  // the previous word. Once busy drops, the word is sent on the next cycle.
  task automatic test_busy(input logic [31:0] prevWord);
    int sB, rB;
    sB = sendTotal; rB = totalReads;
    loadConfig(16'd0, 16'd0);
    busy = 1'b1;
    pulseArm();
    applyStimulus(1'b1, 1'b1, 32'h3000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitReads(rB + 1, 50);
    cyc(10);
    checks++;
    if (sendTotal !== sB || send !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_nosend: got sends %0d expected 0", sendTotal - sB);
    end
    checks++;
    if (dataOut !== prevWord) begin
      errors++;
      $display("[TB] FAIL busy_dataOut: got %h expected %h", dataOut, prevWord);
    end
    busy = 1'b0;
    cyc(1);
    checks++;
    if (send !== 1'b1 || dataOut !== 32'hA000_0000 + rB) begin
      errors++;
      $display("[TB] FAIL busy_release: got send %b data %h expected 1 %h", send, dataOut, 32'hA000_0000 + rB);
    end
    cyc(1);
    checks++;
    if (send !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_single_send: got %b expected 0", send);
    end
  endtask

  // In SAMPLE, run without validIn is ignored. With D=1 the later triggered
  // sample is write 3, so the tag must land on write 4.
  task automatic test_runNoValid();
    int wB, sB;
    wB = wrTotal; sB = sendTotal;
    loadConfig(16'd0, 16'd1);
    pulseArm();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'h4FFF_0000 + k);
    checks++;
    if (wrTotal !== wB) begin
      errors++;
      $display("[TB] FAIL runnovalid_nowrite: got %0d writes expected 0", wrTotal - wB);
    end
    applyStimulus(1'b1, 1'b0, 32'h4000_0000);
    applyStimulus(1'b1, 1'b0, 32'h4000_0001);
    applyStimulus(1'b1, 1'b1, 32'h4000_0002);
    applyStimulus(1'b1, 1'b0, 32'h4000_0003);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitSends(sB + 1, 100);
    cyc(5);
    checks++;
    if (wrTotal - wB !== 4 || lastIdx !== wB + 3) begin
      errors++;
      $display("[TB] FAIL runnovalid_trigger: got writes %0d lastIdx %0d expected 4 %0d", wrTotal - wB, lastIdx, wB + 3);
    end
    checks++;
    if (sendTotal - sB !== 1) begin
      errors++;
      $display("[TB] FAIL runnovalid_sends: got %0d expected 1", sendTotal - sB);
    end
  endtask

  // Arm while the second word is in flight: the pending word is dropped and
  // the block goes back to SAMPLE with cnt=0. A fresh capture then returns
  // the full R+1 words.
  task automatic test_abort();
    int sB, rB, wB;
    sB = sendTotal; rB = totalReads;
    loadConfig(16'd3, 16'd0);
    pulseArm();
    applyStimulus(1'b1, 1'b1, 32'h5000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitSends(sB + 1, 100);
    waitReads(rB + 2, 100);
    pulseArm();
    checks++;
    if ({memoryWrite, memoryRead, send} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_strobes: got %b expected 000", {memoryWrite, memoryRead, send});
    end
    cyc(10);
    checks++;
    if (sendTotal - sB !== 1 || totalReads - rB !== 2) begin
      errors++;
      $display("[TB] FAIL abort_stopped: got sends %0d reads %0d expected 1 2", sendTotal - sB, totalReads - rB);
    end
    checks++;
    if (sendLog[sB % 1024] !== 32'hA000_0000 + rB) begin
      errors++;
      $display("[TB] FAIL abort_first_word: got %h expected %h", sendLog[sB % 1024], 32'hA000_0000 + rB);
    end
    wB = wrTotal;
    applyStimulus(1'b1, 1'b0, 32'h5100_0000);
    checks++;
    if (memoryWrite !== 1'b1 || memWrData !== 32'h5100_0000) begin
      errors++;
      $display("[TB] FAIL abort_resume_write: got %b %h expected 1 51000000", memoryWrite, memWrData);
    end
    applyStimulus(1'b1, 1'b1, 32'h5100_0001);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitSends(sB + 5, 400);
    cyc(5);
    checks++;
    if (wrTotal - wB !== 2 || sendTotal - sB !== 5) begin
      errors++;
      $display("[TB] FAIL abort_recapture: got writes %0d sends %0d expected 2 5", wrTotal - wB, sendTotal - sB);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sendLog[(sB + 1 + k) % 1024] !== 32'hA000_0000 + rB + 2 + k) begin
        errors++;
        $display("[TB] FAIL abort_send%0d: got %h expected %h", k, sendLog[(sB + 1 + k) % 1024], 32'hA000_0000 + rB + 2 + k);
      end
    end
  endtask

  // Asynchronous reset in the middle of DELAY: the outputs clear at once and
  // arm has no effect while reset is low. The size register is cleared too,
  // so the next capture runs with R=0, D=0.
  task automatic test_resetMid();
    int wB, sB, lB;
    loadConfig(16'd1, 16'd5);
    pulseArm();
    applyStimulus(1'b1, 1'b1, 32'h6000_0000);
    applyStimulus(1'b1, 1'b0, 32'h6000_0001);
    applyStimulus(1'b1, 1'b0, 32'h6000_0002);
    checks++;
    if (memoryWrite !== 1'b1 || memWrData !== 32'h6000_0002) begin
      errors++;
      $display("[TB] FAIL resetmid_pre: got %b %h expected 1 60000002", memoryWrite, memWrData);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({memoryWrite, memoryLastWrite, memoryRead, send} !== 4'b0000 || memWrData !== 32'h0 || dataOut !== 32'h0) begin
      errors++;
      $display("[TB] FAIL resetmid_async: got %b %h %h expected 0000 0 0", {memoryWrite, memoryLastWrite, memoryRead, send}, memWrData, dataOut);
    end
    validIn = 1'b0;
    run     = 1'b0;
    arm     = 1'b1;
    cyc(2);
    arm     = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    wB = wrTotal; sB = sendTotal; lB = lastTotal;
    applyStimulus(1'b1, 1'b0, 32'h6100_0000);
    cyc(3);
    checks++;
    if (wrTotal !== wB || sendTotal !== sB) begin
      errors++;
      $display("[TB] FAIL resetmid_idle: got writes %0d sends %0d expected 0 0", wrTotal - wB, sendTotal - sB);
    end
    pulseArm();
    applyStimulus(1'b1, 1'b1, 32'h7000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitSends(sB + 1, 100);
    cyc(5);
    checks++;
    if (wrTotal - wB !== 1 || lastTotal - lB !== 1 || sendTotal - sB !== 1) begin
      errors++;
      $display("[TB] FAIL resetmid_cleared_cfg: got writes %0d last %0d sends %0d expected 1 1 1", wrTotal - wB, lastTotal - lB, sendTotal - sB);
    end
  endtask

  // Run the scenarios in order, then check the whole-run invariants.
  initial begin
    logic [31:0] zeroWord;
    reset_n     = 1'b0;
    validIn     = 1'b0;
    dataIn      = '0;
    run         = 1'b0;
    arm         = 1'b0;
    wrSize      = 1'b0;
    config_data = '0;
    busy        = 1'b0;
    test_reset();
    test_basic();
    test_zero(zeroWord);
    test_busy(zeroWord);
    test_runNoValid();
    test_abort();
    test_resetMid();
    checks++;
    if (exclViol !== 0) begin
      errors++;
      $display("[TB] FAIL strobe_exclusive: got %0d overlapping cycles expected 0", exclViol);
    end
    checks++;
    if (orphanLast !== 0) begin
      errors++;
      $display("[TB] FAIL last_without_write: got %0d expected 0", orphanLast);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
